// File: rtl/flag_sequencer.sv
// Flag sequencer: chooses which flag index a video pipeline displays.
// Manual next/prev button edges, direct index loads and a timed auto-advance
// are held as a pending request and applied only at frame_start, so the
// selector never changes mid-frame.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   frame_start   : one-cycle pulse at the start of vertical blank
//   btn_next/prev : pre-synchronised button levels; a rising edge is a request
//   auto_en       : enable the timed auto-advance
//   load_valid    : one-cycle strobe carrying load_idx (clamped to the last flag)
//   active        : pixel is in the visible area
//   color_in      : colour from the flag lookup for the current selector
//   selector      : current flag index (registered)
//   color_out     : registered pixel colour, zero outside the visible area
//   flag_changed  : one-cycle pulse together with a selector change
module flag_sequencer #(
  parameter int unsigned NUM_FLAGS    = 82,
  parameter int unsigned IDX_W        = 7,
  parameter int unsigned COLOR_W      = 6,
  parameter int unsigned DWELL_FRAMES = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               auto_en,
  input  logic               load_valid,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic               active,
  input  logic [COLOR_W-1:0] color_in,
  output logic [IDX_W-1:0]   selector,
  output logic [COLOR_W-1:0] color_out,
  output logic               flag_changed
);

  localparam int unsigned DWELL_W = 16;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PEND_NEXT = 2'd1;
  localparam logic [1:0] PEND_PREV = 2'd2;
  localparam logic [1:0] PEND_LOAD = 2'd3;

  localparam logic [IDX_W-1:0]   MAX_IDX    = IDX_W'(NUM_FLAGS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

  logic [1:0]         state, state_nx;
  logic [IDX_W-1:0]   pend_idx, pend_idx_nx;
  logic [DWELL_W-1:0] dwell, dwell_nx;
  logic [IDX_W-1:0]   sel_nx;
  logic               next_q, prev_q;

  logic               next_edge, prev_edge;
  logic               new_next, new_prev;
  logic [1:0]         merged;
  logic [IDX_W-1:0]   pend_merged;
  logic [IDX_W-1:0]   sel_inc, sel_dec;

  // Request decode, pending-request merge, frame-boundary apply and dwell timer
  always_comb begin
    state_nx    = state;
    pend_idx_nx = pend_idx;
    dwell_nx    = dwell;
    sel_nx      = selector;
    merged      = state;
    pend_merged = pend_idx;

    next_edge = btn_next & ~next_q;
    prev_edge = btn_prev & ~prev_q;
    // Simultaneous next and prev edges cancel; a load masks both.
    new_next  = ~load_valid & next_edge & ~prev_edge;
    new_prev  = ~load_valid & prev_edge & ~next_edge;

    sel_inc = (selector == MAX_IDX) ? '0 : selector + 1'b1;
    sel_dec = (selector == '0) ? MAX_IDX : selector - 1'b1;

    // A new request replaces a pending one only if it ranks at least as high.
    if (load_valid) begin
      merged      = PEND_LOAD;
      pend_merged = (load_idx > MAX_IDX) ? MAX_IDX : load_idx;
    end else if (new_next && state != PEND_LOAD) begin
      merged = PEND_NEXT;
    end else if (new_prev && (state == IDLE || state == PEND_PREV)) begin
      merged = PEND_PREV;
    end

    state_nx    = merged;
    pend_idx_nx = pend_merged;

    if (frame_start) begin
      state_nx = IDLE;
      case (merged)
        PEND_NEXT: begin sel_nx = sel_inc;     dwell_nx = '0; end
        PEND_PREV: begin sel_nx = sel_dec;     dwell_nx = '0; end
        PEND_LOAD: begin sel_nx = pend_merged; dwell_nx = '0; end
        default: begin
          if (auto_en) begin
            if (dwell >= DWELL_LAST) begin
              sel_nx   = sel_inc;
              dwell_nx = '0;
            end else begin
              dwell_nx = dwell + 1'b1;
            end
          end
        end
      endcase
    end

    if (!auto_en) dwell_nx = '0;
  end

  // State, selector and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pend_idx     <= '0;
      dwell        <= '0;
      selector     <= '0;
      flag_changed <= 1'b0;
      color_out    <= '0;
      // Preload history so a button held through reset is not an edge.
      next_q       <= btn_next;
      prev_q       <= btn_prev;
    end else begin
      state        <= state_nx;
      pend_idx     <= pend_idx_nx;
      dwell        <= dwell_nx;
      selector     <= sel_nx;
      flag_changed <= (sel_nx != selector);
      color_out    <= active ? color_in : '0;
      next_q       <= btn_next;
      prev_q       <= btn_prev;
    end
  end

endmodule

// File: tb/tb_flag_sequencer.sv
// Directed bench for flag_sequencer with a scoreboard: each stimulus that
// should move the selector pushes the expected index; a monitor pops and
// compares whenever flag_changed pulses.
module tb_flag_sequencer;

  localparam int unsigned IDX_W   = 7;
  localparam int unsigned COLOR_W = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_start;
  logic               btn_next;
  logic               btn_prev;
  logic               auto_en;
  logic               load_valid;
  logic [IDX_W-1:0]   load_idx;
  logic               active;
  logic [COLOR_W-1:0] color_in;
  logic [IDX_W-1:0]   selector;
  logic [COLOR_W-1:0] color_out;
  logic               flag_changed;

  int total = 0;
  int bad   = 0;
  logic [IDX_W-1:0] exp_q[$];

  flag_sequencer #(
    .NUM_FLAGS(82), .IDX_W(IDX_W), .COLOR_W(COLOR_W), .DWELL_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .btn_next(btn_next), .btn_prev(btn_prev), .auto_en(auto_en),
    .load_valid(load_valid), .load_idx(load_idx), .active(active),
    .color_in(color_in), .selector(selector), .color_out(color_out),
    .flag_changed(flag_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every flag_changed pulse must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (flag_changed) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", int'(selector), -1);
      end else begin
        check("change_value", int'(selector), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(1);
  endtask

  task automatic press_next();
    btn_next = 1'b1; tick(1); btn_next = 1'b0; tick(1);
  endtask

  task automatic press_prev();
    btn_prev = 1'b1; tick(1); btn_prev = 1'b0; tick(1);
  endtask

  task automatic load(input int idx);
    load_valid = 1'b1; load_idx = IDX_W'(idx); tick(1);
    load_valid = 1'b0; tick(1);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    auto_en = 1'b0; load_valid = 1'b0; load_idx = '0; active = 1'b0;
    color_in = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("reset_selector", int'(selector), 0);
    check("reset_color", int'(color_out), 0);
    check("reset_changed", int'(flag_changed), 0);

    // Reach the last flag, then next wraps to 0 with a single pulse
    load(81); exp_q.push_back(81); frame();
    check("load_81", int'(selector), 81);
    press_next(); exp_q.push_back(0);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    check("wrap_next_sel", int'(selector), 0);
    check("wrap_next_pulse", int'(flag_changed), 1);
    tick(1);
    check("wrap_next_pulse_end", int'(flag_changed), 0);

    // Prev at 0 waits for the frame boundary, then wraps to 81
    press_prev();
    tick(1000);
    check("prev_held", int'(selector), 0);
    exp_q.push_back(81); frame();
    check("wrap_prev", int'(selector), 81);

    // Clamped load beats a same-cycle next; loading the current index is silent
    load_valid = 1'b1; load_idx = 7'd100; btn_next = 1'b1; tick(1);
    load_valid = 1'b0; btn_next = 1'b0; tick(1);
    frame();
    check("clamp_load_wins", int'(selector), 81);
    check("same_idx_no_pulse", int'(flag_changed), 0);

    // Request arriving with frame_start applies at that frame_start
    btn_next = 1'b1; frame_start = 1'b1; exp_q.push_back(0); tick(1);
    btn_next = 1'b0; frame_start = 1'b0; tick(1);
    check("same_cycle_req", int'(selector), 0);

    // Simultaneous next and prev edges cancel
    btn_next = 1'b1; btn_prev = 1'b1; tick(1);
    btn_next = 1'b0; btn_prev = 1'b0; tick(1);
    frame();
    check("cancel", int'(selector), 0);

    // Pending prev overwritten by next; pending next not overwritten by prev
    press_prev(); press_next(); exp_q.push_back(1); frame();
    check("next_over_prev", int'(selector), 1);
    press_next(); press_prev(); exp_q.push_back(2); frame();
    check("prev_not_over_next", int'(selector), 2);
    // Pending load survives later button edges
    load(40); press_next(); press_prev(); exp_q.push_back(40); frame();
    check("load_sticky", int'(selector), 40);

    // Auto-advance every 3 frames
    load(5); exp_q.push_back(5); frame();
    auto_en = 1'b1;
    frame(); frame();
    check("auto_wait", int'(selector), 5);
    exp_q.push_back(6); frame();
    check("auto_3rd", int'(selector), 6);
    frame(); frame(); exp_q.push_back(7); frame();
    check("auto_6th", int'(selector), 7);
    // A manual change restarts the dwell count
    frame(); frame();
    press_next(); exp_q.push_back(8); frame();
    check("manual_during_auto", int'(selector), 8);
    frame(); frame();
    check("dwell_restart", int'(selector), 8);
    exp_q.push_back(9); frame();
    check("auto_after_manual", int'(selector), 9);
    // Dropping auto_en clears the count
    frame(); frame();
    auto_en = 1'b0; tick(1); auto_en = 1'b1;
    frame(); frame();
    check("auto_en_clears", int'(selector), 9);
    exp_q.push_back(10); frame();
    check("auto_after_clear", int'(selector), 10);
    auto_en = 1'b0;

    // Colour register
    active = 1'b1; color_in = 6'h30; tick(1);
    check("color_active", int'(color_out), 'h30);
    active = 1'b0; tick(1);
    check("color_blank", int'(color_out), 0);

    // Reset discards a pending next; held button is not an edge after reset
    btn_next = 1'b1; tick(1);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    frame();
    check("reset_discard_sel", int'(selector), 0);
    check("reset_discard_pulse", int'(flag_changed), 0);
    btn_next = 1'b0; tick(2);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
